// File: rtl/gpio_port_pkg.sv
// Shared constants for the GPIO port controller: register word indices
// and the debounce counter width.
package gpio_port_pkg;

  // Debounce counter width; wide enough for DB_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

  // Register word indices; 6 and 7 are reserved (read 0, writes ignored).
  typedef enum logic [2:0] {
    REG_DATAOUT = 3'd0,
    REG_OUTEN   = 3'd1,
    REG_DATAIN  = 3'd2,
    REG_INTEN   = 3'd3,
    REG_INTPOL  = 3'd4,
    REG_INTSTAT = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_idx_e;

endpackage

// File: rtl/gpio_pin_filter.sv
// Single-pin input conditioning: 2-flop synchronizer followed by a
// debounce filter that accepts a change only after DB_CYCLES consecutive
// cycles of disagreement with the current debounced value.
module gpio_pin_filter
  import gpio_port_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_db
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // Two-stage synchronizer for the asynchronous pad input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count disagreeing cycles, restart on any agreement.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_LAST) begin
      r_db  <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: register file, pin edge detection, sticky
// interrupt status with write-1-to-clear, and registered interrupt output.
module gpio_port_ctrl
  import gpio_port_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [2:0]       ADDR,
  input  logic             WE,
  input  logic             RE,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  output logic [WIDTH-1:0] POUT,
  output logic [WIDTH-1:0] POUT_EN,
  input  logic [WIDTH-1:0] PIN,
  output logic             IRQ
);

  reg_idx_e         w_addr;
  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_rdata;

  logic [WIDTH-1:0] r_dataout;
  logic [WIDTH-1:0] r_outen;
  logic [WIDTH-1:0] r_inten;
  logic [WIDTH-1:0] r_intpol;
  logic [WIDTH-1:0] r_intstat;
  logic [WIDTH-1:0] r_db_prev;
  logic [WIDTH-1:0] r_rdata;
  logic             r_irq;

  assign w_addr = reg_idx_e'(ADDR);

  // Per-pin synchronizer + debounce.
  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpio_pin_filter #(
      .DB_CYCLES(DB_CYCLES)
    ) u_filter (
      .i_clk(HCLK),
      .i_rst(HRESET),
      .i_pin(PIN[g]),
      .o_db (w_db[g])
    );
  end

  // Writable control registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dataout <= '0;
      r_outen   <= '0;
      r_inten   <= '0;
      r_intpol  <= '0;
    end else if (WE) begin
      case (w_addr)
        REG_DATAOUT: r_dataout <= WDATA;
        REG_OUTEN:   r_outen   <= WDATA;
        REG_INTEN:   r_inten   <= WDATA;
        REG_INTPOL:  r_intpol  <= WDATA;
        default:     ;
      endcase
    end
  end

  // Edge detect against the previous debounced value; polarity only
  // selects which transition qualifies, so a polarity write alone
  // cannot create an edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_db_prev <= '0;
    else        r_db_prev <= w_db;
  end

  assign w_rise = w_db & ~r_db_prev;
  assign w_fall = ~w_db & r_db_prev;
  assign w_edge = (w_rise & ~r_intpol) | (w_fall & r_intpol);
  assign w_w1c  = (WE && (w_addr == REG_INTSTAT)) ? WDATA : '0;

  // Sticky status: clear is applied before set so a same-cycle edge wins.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_intstat <= '0;
    else        r_intstat <= (r_intstat & ~w_w1c) | w_edge;
  end

  // Registered interrupt output.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_irq <= 1'b0;
    else        r_irq <= |(r_intstat & r_inten);
  end

  // Read mux over current (pre-write) register contents.
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      REG_DATAOUT: w_rdata = r_dataout;
      REG_OUTEN:   w_rdata = r_outen;
      REG_DATAIN:  w_rdata = w_db;
      REG_INTEN:   w_rdata = r_inten;
      REG_INTPOL:  w_rdata = r_intpol;
      REG_INTSTAT: w_rdata = r_intstat;
      default:     w_rdata = '0;
    endcase
  end

  // Read data register, held while RE is low.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)  r_rdata <= '0;
    else if (RE) r_rdata <= w_rdata;
  end

  assign RDATA   = r_rdata;
  assign POUT    = r_dataout;
  assign POUT_EN = r_outen;
  assign IRQ     = r_irq;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed bench for gpio_port_ctrl (WIDTH=8, DB_CYCLES=4).
module tb_gpio_port_ctrl;

  logic       HCLK;
  logic       HRESET;
  logic [2:0] ADDR;
  logic       WE;
  logic       RE;
  logic [7:0] WDATA;
  logic [7:0] RDATA;
  logic [7:0] POUT;
  logic [7:0] POUT_EN;
  logic [7:0] PIN;
  logic       IRQ;

  int n_cmp;
  int n_err;

  gpio_port_ctrl #(
    .WIDTH(8),
    .DB_CYCLES(4)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .ADDR(ADDR),
    .WE(WE),
    .RE(RE),
    .WDATA(WDATA),
    .RDATA(RDATA),
    .POUT(POUT),
    .POUT_EN(POUT_EN),
    .PIN(PIN),
    .IRQ(IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Bus write: drive on a falling edge, strobe covers one rising edge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge HCLK);
    ADDR = a; WDATA = d; WE = 1'b1;
    @(negedge HCLK);
    WE = 1'b0;
  endtask

  // Bus read: RDATA sampled on the falling edge after the capturing edge.
  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge HCLK);
    ADDR = a; RE = 1'b1;
    @(negedge HCLK);
    RE = 1'b0;
    d = RDATA;
  endtask

  task automatic test_reset;
    HRESET = 1'b1; ADDR = '0; WE = 1'b0; RE = 1'b0; WDATA = '0; PIN = '0;
    repeat (3) @(negedge HCLK);
    n_cmp++; if (POUT !== 8'h00)    begin n_err++; $display("FAIL reset_pout: got %h expected 00", POUT); end
    n_cmp++; if (POUT_EN !== 8'h00) begin n_err++; $display("FAIL reset_pout_en: got %h expected 00", POUT_EN); end
    n_cmp++; if (RDATA !== 8'h00)   begin n_err++; $display("FAIL reset_rdata: got %h expected 00", RDATA); end
    n_cmp++; if (IRQ !== 1'b0)      begin n_err++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
    HRESET = 1'b0;
  endtask

  task automatic test_regs;
    logic [7:0] d;
    wr(3'd0, 8'hA5);
    n_cmp++; if (POUT !== 8'hA5)    begin n_err++; $display("FAIL pout: got %h expected a5", POUT); end
    wr(3'd1, 8'h0F);
    n_cmp++; if (POUT_EN !== 8'h0F) begin n_err++; $display("FAIL pout_en: got %h expected 0f", POUT_EN); end
    rd(3'd1, d);
    n_cmp++; if (d !== 8'h0F) begin n_err++; $display("FAIL rd_outen: got %h expected 0f", d); end
    rd(3'd0, d);
    n_cmp++; if (d !== 8'hA5) begin n_err++; $display("FAIL rd_dataout: got %h expected a5", d); end
    wr(3'd6, 8'hFF);
    rd(3'd6, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rd_rsvd6: got %h expected 00", d); end
    rd(3'd7, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rd_rsvd7: got %h expected 00", d); end
    wr(3'd4, 8'h5A);
    rd(3'd4, d);
    n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL rd_intpol: got %h expected 5a", d); end
    wr(3'd4, 8'h00);
    // Read and write together return the old value; write lands anyway.
    @(negedge HCLK);
    ADDR = 3'd0; WDATA = 8'h3C; WE = 1'b1; RE = 1'b1;
    @(negedge HCLK);
    WE = 1'b0; RE = 1'b0;
    n_cmp++; if (RDATA !== 8'hA5) begin n_err++; $display("FAIL rw_same_cycle_rdata: got %h expected a5", RDATA); end
    n_cmp++; if (POUT !== 8'h3C)  begin n_err++; $display("FAIL rw_same_cycle_pout: got %h expected 3c", POUT); end
    @(negedge HCLK);
    n_cmp++; if (RDATA !== 8'hA5) begin n_err++; $display("FAIL rdata_hold: got %h expected a5", RDATA); end
  endtask

  task automatic test_debounce;
    logic [7:0] d;
    logic [7:0] exp;
    @(negedge HCLK);
    PIN[3] = 1'b1; ADDR = 3'd2; RE = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge HCLK);
      exp = (k >= 7) ? 8'h08 : 8'h00;
      n_cmp++;
      if (RDATA !== exp) begin n_err++; $display("FAIL datain_latency k=%0d: got %h expected %h", k, RDATA, exp); end
    end
    RE = 1'b0;
    repeat (2) @(negedge HCLK);
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h08) begin n_err++; $display("FAIL intstat_rise: got %h expected 08", d); end
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b expected 0", IRQ); end
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    @(negedge HCLK);
    PIN[0] = 1'b1;
    repeat (3) @(negedge HCLK);
    PIN[0] = 1'b0;
    repeat (10) @(negedge HCLK);
    rd(3'd2, d);
    n_cmp++; if (d !== 8'h08) begin n_err++; $display("FAIL glitch_datain: got %h expected 08", d); end
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h08) begin n_err++; $display("FAIL glitch_intstat: got %h expected 08", d); end
    // Exactly DB_CYCLES long pulse is accepted.
    @(negedge HCLK);
    PIN[1] = 1'b1;
    repeat (4) @(negedge HCLK);
    PIN[1] = 1'b0;
    repeat (12) @(negedge HCLK);
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h0A) begin n_err++; $display("FAIL pulse4_intstat: got %h expected 0a", d); end
    rd(3'd2, d);
    n_cmp++; if (d !== 8'h08) begin n_err++; $display("FAIL pulse4_datain: got %h expected 08", d); end
    wr(3'd5, 8'h0A);
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL w1c_clear: got %h expected 00", d); end
  endtask

  task automatic test_fall_irq;
    logic [7:0] d;
    logic       exp;
    wr(3'd3, 8'h01);
    wr(3'd4, 8'h01);
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL intpol_change_intstat: got %h expected 00", d); end
    @(negedge HCLK);
    PIN[0] = 1'b1;
    repeat (10) @(negedge HCLK);
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rise_ignored_fallpol: got %h expected 00", d); end
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_before_fall: got %b expected 0", IRQ); end
    @(negedge HCLK);
    PIN[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge HCLK);
      exp = (k >= 8);
      n_cmp++;
      if (IRQ !== exp) begin n_err++; $display("FAIL irq_latency k=%0d: got %b expected %b", k, IRQ, exp); end
    end
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL intstat_fall: got %h expected 01", d); end
    wr(3'd5, 8'h01);
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL irq_clear_edge: got %b expected 1", IRQ); end
    @(negedge HCLK);
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_after_clear: got %b expected 0", IRQ); end
    wr(3'd4, 8'h00);
    wr(3'd3, 8'h00);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    @(negedge HCLK);
    PIN[2] = 1'b1;
    repeat (6) @(negedge HCLK);
    ADDR = 3'd5; WDATA = 8'h04; WE = 1'b1;
    @(negedge HCLK);
    WE = 1'b0;
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h04) begin n_err++; $display("FAIL w1c_collision: got %h expected 04", d); end
    rd(3'd2, d);
    n_cmp++; if (d !== 8'h0C) begin n_err++; $display("FAIL datain_pins23: got %h expected 0c", d); end
    wr(3'd5, 8'h04);
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL w1c_after_collision: got %h expected 00", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    @(negedge HCLK);
    PIN = '0;
    repeat (10) @(negedge HCLK);
    rd(3'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL settle_datain: got %h expected 00", d); end
    wr(3'd1, 8'hFF);
    n_cmp++; if (POUT_EN !== 8'hFF) begin n_err++; $display("FAIL outen_ff: got %h expected ff", POUT_EN); end
    wr(3'd3, 8'hFF);
    @(negedge HCLK);
    PIN[5] = 1'b1;
    repeat (3) @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    n_cmp++; if (POUT_EN !== 8'h00) begin n_err++; $display("FAIL async_reset_pout_en: got %h expected 00", POUT_EN); end
    PIN[5] = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;
    repeat (12) @(negedge HCLK);
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL aborted_intstat: got %h expected 00", d); end
    rd(3'd2, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL aborted_datain: got %h expected 00", d); end
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL aborted_irq: got %b expected 0", IRQ); end
    // Pin held high across reset release yields a single rising edge.
    @(negedge HCLK);
    PIN[6] = 1'b1; HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (12) @(negedge HCLK);
    rd(3'd2, d);
    n_cmp++; if (d !== 8'h40) begin n_err++; $display("FAIL held_pin_datain: got %h expected 40", d); end
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h40) begin n_err++; $display("FAIL held_pin_intstat: got %h expected 40", d); end
    wr(3'd5, 8'h40);
    repeat (10) @(negedge HCLK);
    rd(3'd5, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL held_pin_single_edge: got %h expected 00", d); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_regs;
    test_debounce;
    test_glitch;
    test_fall_irq;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
